// File: rtl/font_loader_pkg.sv
// Shared types and defaults for the runtime-reloadable glyph font memory.
package font_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_e;

  localparam int GLYPH_COUNT = 10;
  localparam int GLYPH_ROWS  = 19;
  localparam int FONT_DEPTH  = GLYPH_COUNT * GLYPH_ROWS;

  function automatic int bytes_per_word(input int dw);
    return (dw + 7) / 8;
  endfunction
endpackage

// File: rtl/font_dpram.sv
// Simple dual-port font RAM: synchronous write, registered read-before-write read port.
module font_dpram #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);
  logic [data_width-1:0] mem_q [2**addr_width];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/font_ram_loader.sv
// Packs an MSB-first byte stream into font words and writes them sequentially
// into the font RAM, which the renderer reads with 1-cycle latency.
module font_ram_loader
  import font_loader_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int depth      = FONT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_dout
);
  localparam int BPW   = bytes_per_word(data_width);
  localparam int ASM_W = 8 * BPW;
  localparam logic [1:0]            LAST_IDX  = 2'(BPW - 1);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

  ld_state_e             state_q;
  logic                  busy_q, done_q, rd_vld_q;
  logic [addr_width-1:0] addr_q;
  logic [1:0]            idx_q;
  logic [ASM_W-1:0]      asm_q;

  logic                  accept, we;
  logic [ASM_W-1:0]      word_full;
  logic [data_width-1:0] ram_rdata;

  // abort masks the handshake so a cancelled cycle never consumes a byte
  assign s_ready   = busy_q & ~abort;
  assign accept    = s_ready & s_valid;
  assign word_full = (asm_q << 8) | ASM_W'(s_data);
  assign we        = accept && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            idx_q   <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else if (accept) begin
            if (idx_q != LAST_IDX) begin
              asm_q <= word_full;
              idx_q <= idx_q + 2'd1;
            end else begin
              idx_q <= '0;
              if (addr_q == LAST_ADDR) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM output register has no reset; hold rd_dout at 0 until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_vld_q <= 1'b0;
    else          rd_vld_q <= 1'b1;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_dout = rd_vld_q ? ram_rdata : '0;

  font_dpram #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(addr_q),
    .wdata_i(word_full[data_width-1:0]),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );
endmodule

// File: tb/tb_font_ram_loader.sv
// Directed bench for font_ram_loader: 16-bit and 4-bit builds, loads, abort, reset, collision.
module tb_font_ram_loader;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0, rd_addr = '0;
  logic       s_ready, busy, done;
  logic [15:0] rd_dout;

  logic       start4 = 1'b0, s_valid4 = 1'b0;
  logic [7:0] s_data4 = '0, rd_addr4 = '0;
  logic       s_ready4, busy4, done4;
  logic [3:0] rd_dout4;

  int n_tests = 0, n_fail = 0;
  int rdy_cnt, done_cnt, busy_low;

  always #5 clk = ~clk;

  font_ram_loader #(.addr_width(8), .data_width(16), .depth(190)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_dout(rd_dout));

  font_ram_loader #(.addr_width(8), .data_width(4), .depth(190)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .abort(1'b0),
    .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4), .busy(busy4), .done(done4),
    .rd_addr(rd_addr4), .rd_dout(rd_dout4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic rd16(input string tag, input logic [7:0] a, input logic [15:0] e);
    rd_addr = a;
    @(negedge clk);
    chk(tag, 32'(rd_dout), 32'(e));
  endtask

  // word i = base | i, high byte first; ck >= 0 watches a read/write collision on word ck
  task automatic stream(input int nbytes, input bit gaps, input logic [15:0] base,
                        input int ck, input logic [15:0] ck_old);
    rdy_cnt = 0; done_cnt = 0; busy_low = 0;
    for (int i = 0; i < nbytes; i++) begin
      logic [15:0] w;
      w = base | 16'(i / 2);
      if (gaps)
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 0; g++) begin
          s_valid = 1'b0;
          if (!busy) busy_low++;
          if (done) done_cnt++;
          @(negedge clk);
        end
      if (ck >= 0 && i == 2*ck + 1) rd_addr = 8'(ck);
      if (ck >= 0 && i == 2*ck + 2) chk("coll_old", 32'(rd_dout), 32'(ck_old));
      if (ck >= 0 && i == 2*ck + 3) chk("coll_new", 32'(rd_dout), 32'(base | 16'(ck)));
      s_valid = 1'b1;
      s_data  = i[0] ? w[7:0] : w[15:8];
      if (s_ready) rdy_cnt++;
      if (!busy) busy_low++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;
    #12;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_rd_dout", 32'(rd_dout), 0);
    @(negedge clk); reset_n = 1'b1;

    // start with abort stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);

    // full load, no gaps
    kick();
    stream(380, 1'b0, 16'hA500, -1, 16'h0);
    chk("t1_ready_cycles", 32'(rdy_cnt), 380);
    chk("t1_busy_low", 32'(busy_low), 0);
    chk("t1_early_done", 32'(done_cnt), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_ready_off", 32'(s_ready), 0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    rd16("t1_rd0", 8'd0, 16'hA500);
    rd16("t1_rd1", 8'd1, 16'hA501);
    rd16("t1_rd189", 8'd189, 16'hA5BD);

    // same load with random gaps
    kick();
    stream(380, 1'b1, 16'hA500, -1, 16'h0);
    chk("t2_busy_low", 32'(busy_low), 0);
    chk("t2_early_done", 32'(done_cnt), 0);
    chk("t2_done", 32'(done), 1);
    @(negedge clk);
    chk("t2_done_pulse", 32'(done), 0);
    rd16("t2_rd0", 8'd0, 16'hA500);
    rd16("t2_rd95", 8'd95, 16'hA55F);
    rd16("t2_rd189", 8'd189, 16'hA5BD);

    // abort after 60 words + 1 byte; the abort cycle offers the byte that would finish word 60
    kick();
    stream(121, 1'b0, 16'h5A00, -1, 16'h0);
    s_valid = 1'b1; s_data = 8'h3C; abort = 1'b1;
    #1 chk("t3_abort_ready", 32'(s_ready), 0);
    @(negedge clk); abort = 1'b0; s_valid = 1'b0;
    chk("t3_busy_off", 32'(busy), 0);
    d = 0;
    repeat (4) begin
      if (done) d++;
      @(negedge clk);
    end
    chk("t3_no_done", 32'(d), 0);
    rd16("t3_rd58", 8'd58, 16'h5A3A);
    rd16("t3_rd59", 8'd59, 16'h5A3B);
    rd16("t3_rd60", 8'd60, 16'hA53C);

    // restart full load, watching collision on word 10 (old 5A0A -> new A50A)
    kick();
    stream(380, 1'b0, 16'hA500, 10, 16'h5A0A);
    chk("t4_done", 32'(done), 1);
    rd16("t4_rd0", 8'd0, 16'hA500);
    rd16("t4_rd59", 8'd59, 16'hA53B);
    rd16("t4_rd60", 8'd60, 16'hA53C);

    // reset after 100 bytes
    kick();
    stream(100, 1'b0, 16'h3C00, -1, 16'h0);
    s_valid = 1'b1; s_data = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(s_ready), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_rd_dout", 32'(rd_dout), 0);
    @(negedge clk); reset_n = 1'b1; s_valid = 1'b0;
    rd16("t5_rd0", 8'd0, 16'h3C00);
    rd16("t5_rd49", 8'd49, 16'h3C31);
    rd16("t5_rd50", 8'd50, 16'hA532);
    kick();
    stream(2, 1'b0, 16'h7700, -1, 16'h0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    rd16("t5_restart_rd0", 8'd0, 16'h7700);
    rd16("t5_restart_rd1", 8'd1, 16'h3C01);

    // 4-bit build, one byte per word
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    rdy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 190; i++) begin
      s_valid4 = 1'b1; s_data4 = 8'hF3;
      if (s_ready4) rdy_cnt++;
      if (done4) done_cnt++;
      @(negedge clk);
    end
    s_valid4 = 1'b0;
    chk("t6_ready_cycles", 32'(rdy_cnt), 190);
    chk("t6_early_done", 32'(done_cnt), 0);
    chk("t6_done", 32'(done4), 1);
    rd_addr4 = 8'd0;   @(negedge clk); chk("t6_rd0", 32'(rd_dout4), 32'h3);
    rd_addr4 = 8'd100; @(negedge clk); chk("t6_rd100", 32'(rd_dout4), 32'h3);
    rd_addr4 = 8'd189; @(negedge clk); chk("t6_rd189", 32'(rd_dout4), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
